cls381_meas_sched: RTL

CLS381_MEAS_SCHED -- requirements
Module: cls381_meas_sched

---
 rtl/cls381_meas_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cls381_meas_sched.sv
// CLS381 colour-sensor measurement scheduler: periodic read requests, capture, dominant-colour flags.
// Optional CLS_DEBOUNCE_EN: flags change only after DEBOUNCE_N consecutive matching results.
module cls381_meas_sched #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int RD_TIMEOUT    = 4096,
    parameter int DEBOUNCE_N    = 4
) (
    input  logic        i2c_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_done,
    input  logic        rd_done,
    input  logic [23:0] data_r,
    input  logic [23:0] data_g,
    input  logic [23:0] data_b,
    output logic        rd_req,
    output logic        r_valid,
    output logic        g_valid,
    output logic        b_valid,
    output logic [1:0]  color_code,
    output logic [15:0] meas_cnt,
    output logic        timeout_err
);

    localparam int CMAX = (SAMPLE_PERIOD > RD_TIMEOUT) ? SAMPLE_PERIOD : RD_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(RD_TIMEOUT - 1);

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_RED   = 2'b01;
    localparam logic [1:0] C_GREEN = 2'b10;
    localparam logic [1:0] C_BLUE  = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT, REQ, BUSY, EVAL} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           cfg_q;
    logic           rd_req_q;
    logic [2:0]     flags_q;
    logic [1:0]     code_q;
    logic [15:0]    meas_q;
    logic           tmo_q;
    logic [23:0]    r_q, g_q, b_q;
    logic [1:0]     cls_d;

`ifdef CLS_DEBOUNCE_EN
    localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);
    logic [3:0] match_q;
    logic [3:0] match_d;
    logic [1:0] prev_q;
`endif

    function automatic logic [2:0] flags_of(input logic [1:0] c);
        case (c)
            C_RED:   return 3'b100;
            C_GREEN: return 3'b010;
            C_BLUE:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Zero-extended 25-bit operands so the pairwise sums cannot wrap.
    logic [24:0] r_ext, g_ext, b_ext;
    assign r_ext = {1'b0, r_q};
    assign g_ext = {1'b0, g_q};
    assign b_ext = {1'b0, b_q};

    always_comb begin
        cls_d = C_NONE;
        if (r_ext > g_ext + b_ext)
            cls_d = C_RED;
        else if (g_ext > r_ext + b_ext)
            cls_d = C_GREEN;
        else if (b_ext > r_ext + g_ext)
            cls_d = C_BLUE;
    end

`ifdef CLS_DEBOUNCE_EN
    always_comb begin
        match_d = 4'd1;
        if (cls_d == prev_q)
            match_d = (match_q == 4'hF) ? 4'hF : match_q + 4'd1;
    end
`endif

    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cfg_q    <= 1'b0;
            rd_req_q <= 1'b0;
            flags_q  <= 3'b000;
            code_q   <= C_NONE;
            meas_q   <= 16'h0000;
            tmo_q    <= 1'b0;
            r_q      <= 24'h0;
            g_q      <= 24'h0;
            b_q      <= 24'h0;
`ifdef CLS_DEBOUNCE_EN
            match_q  <= 4'd0;
            prev_q   <= C_NONE;
`endif
        end else begin
            cfg_q    <= cfg_done;
            rd_req_q <= 1'b0;
            if (!cfg_done && state_q != IDLE) begin
                // Abort: any outstanding read is dropped; counters/sticky error survive.
                state_q <= IDLE;
                cnt_q   <= '0;
                flags_q <= 3'b000;
                code_q  <= C_NONE;
`ifdef CLS_DEBOUNCE_EN
                match_q <= 4'd0;
                prev_q  <= C_NONE;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        // cfg_done must be seen on two consecutive edges before scheduling starts.
                        if (cfg_done && cfg_q) begin
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end
                    end
                    WAIT: begin
                        if (cnt_q == WAIT_LAST) begin
                            state_q  <= REQ;
                            rd_req_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REQ: begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                    end
                    BUSY: begin
                        if (rd_done) begin
                            r_q     <= data_r;
                            g_q     <= data_g;
                            b_q     <= data_b;
                            state_q <= EVAL;
                        end else if (cnt_q == TO_LAST) begin
                            tmo_q   <= 1'b1;
                            state_q <= WAIT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    EVAL: begin
                        meas_q  <= meas_q + 16'h0001;
                        state_q <= WAIT;
                        cnt_q   <= '0;
`ifdef CLS_DEBOUNCE_EN
                        prev_q  <= cls_d;
                        match_q <= match_d;
                        if (match_d >= DB_N && cls_d != code_q) begin
                            code_q  <= cls_d;
                            flags_q <= flags_of(cls_d);
                        end
`else
                        code_q  <= cls_d;
                        flags_q <= flags_of(cls_d);
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rd_req      = rd_req_q;
    assign r_valid     = flags_q[2];
    assign g_valid     = flags_q[1];
    assign b_valid     = flags_q[0];
    assign color_code  = code_q;
    assign meas_cnt    = meas_q;
    assign timeout_err = tmo_q;

endmodule
